// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length encodings, key geometry and the
// job scheduler state type.
package aes_pkg;

  localparam logic [1:0] KEY128 = 2'd0;
  localparam logic [1:0] KEY192 = 2'd1;
  localparam logic [1:0] KEY256 = 2'd2;
  localparam logic [1:0] KEYBAD = 2'd3;

  localparam int KW128 = 128;
  localparam int KW192 = 192;
  localparam int KW256 = 256;

  // Nk (key words) / Nr (rounds) pairs per key length.
  localparam int NK128 = 4;
  localparam int NR128 = 10;
  localparam int NK192 = 6;
  localparam int NR192 = 12;
  localparam int NK256 = 8;
  localparam int NR256 = 14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } sched_state_t;

  function automatic logic keylen_legal(input logic [1:0] kl);
    return kl != KEYBAD;
  endfunction

endpackage

// File: rtl/aes_job_scheduler_if.sv
// Requester and response channels of the AES job scheduler.
// Handshake: a transfer occurs on a rising clk edge where valid and ready are both 1;
// req_ready depends combinationally on req_valid, resp_valid never depends on resp_ready.
interface aes_job_scheduler_if #(
  parameter int NREQ = 2,
  parameter int IDW  = 3
);
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     req_decrypt;
  logic [2*NREQ-1:0]   req_keylen;
  logic [128*NREQ-1:0] req_data;
  logic [256*NREQ-1:0] req_key;
  logic                resp_valid;
  logic                resp_ready;
  logic [IDW-1:0]      resp_id;
  logic [127:0]        resp_data;
  logic                resp_err;

  modport master (
    output req_valid, req_decrypt, req_keylen, req_data, req_key, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_decrypt, req_keylen, req_data, req_key, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data, resp_err
  );
endinterface

// File: rtl/aes_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past ptr and wraps.
module aes_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any_req
);
  localparam int AW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic          found;
  logic [AW-1:0] idx_w;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx_w     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx_w = AW'((int'(ptr) + i) % NREQ);
      if (!found && req[idx_w]) begin
        found        = 1'b1;
        grant[idx_w] = 1'b1;
        grant_idx    = IDW'(idx_w);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/aes_job_scheduler.sv
// Round-robin scheduler sharing one combinational AES engine between NREQ
// requesters; holds engine inputs for SETTLE_CYCLES then returns the tagged result.
module aes_job_scheduler
  import aes_pkg::*;
#(
  parameter int NREQ          = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int IDW           = 3
) (
  input  logic                clk,
  input  logic                reset,
  aes_job_scheduler_if.slave  bus,
  output logic [127:0]        eng_data,
  output logic [255:0]        eng_key,
  output logic [1:0]          eng_keylen,
  output logic                eng_decrypt,
  output logic                eng_busy,
  input  logic [127:0]        eng_result,
  output sched_state_t        state_dbg
);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

  sched_state_t    state, state_n;
  logic [IDW-1:0]  ptr, grant_idx;
  logic [NREQ-1:0] grant;
  logic            any_req, accept, job_legal;
  logic [CW-1:0]   cnt;
  logic [127:0]    sel_data, resp_data_q;
  logic [255:0]    sel_key;
  logic [1:0]      sel_keylen;
  logic            sel_decrypt, resp_err_q;
  logic [IDW-1:0]  resp_id_q;

  aes_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  // Grant is one-hot, so a priority-free OR-style select is sufficient.
  always_comb begin
    sel_data    = '0;
    sel_key     = '0;
    sel_keylen  = '0;
    sel_decrypt = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_data    = bus.req_data[i*128 +: 128];
        sel_key     = bus.req_key[i*256 +: 256];
        sel_keylen  = bus.req_keylen[i*2 +: 2];
        sel_decrypt = bus.req_decrypt[i];
      end
    end
  end

  assign job_legal = keylen_legal(sel_keylen);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          accept  = 1'b1;
          state_n = job_legal ? ST_RUN : ST_RESP;
        end
      end
      ST_RUN:  if (cnt == '0) state_n = ST_RESP;
      ST_RESP: if (bus.resp_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= IDW'(NREQ - 1);
      cnt         <= '0;
      eng_data    <= '0;
      eng_key     <= '0;
      eng_keylen  <= '0;
      eng_decrypt <= 1'b0;
      resp_id_q   <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else if (accept) begin
      ptr       <= grant_idx;
      resp_id_q <= grant_idx;
      if (job_legal) begin
        eng_data    <= sel_data;
        eng_key     <= sel_key;
        eng_keylen  <= sel_keylen;
        eng_decrypt <= sel_decrypt;
        cnt         <= CNT_LOAD;
        resp_err_q  <= 1'b0;
      end else begin
        // Illegal key length bypasses the engine entirely.
        resp_err_q  <= 1'b1;
        resp_data_q <= '0;
      end
    end else if (state == ST_RUN) begin
      if (cnt == '0) resp_data_q <= eng_result;
      else           cnt <= cnt - 1'b1;
    end
  end

  assign bus.req_ready  = (state == ST_IDLE) ? grant : '0;
  assign bus.resp_valid = (state == ST_RESP);
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;
  assign eng_busy       = (state == ST_RUN);
  assign state_dbg      = state;

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Directed bench for aes_job_scheduler with a lookup-table engine built from
// known AES test vectors.
module tb_aes_job_scheduler;
  import aes_pkg::*;

  localparam int NREQ   = 2;
  localparam int SETTLE = 2;
  localparam int IDW    = 3;

  localparam logic [127:0] P    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_job_scheduler_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  logic [127:0] eng_data, eng_result;
  logic [255:0] eng_key;
  logic [1:0]   eng_keylen;
  logic         eng_decrypt, eng_busy;
  sched_state_t state_dbg;

  aes_job_scheduler #(.NREQ(NREQ), .SETTLE_CYCLES(SETTLE), .IDW(IDW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .eng_data    (eng_data),
    .eng_key     (eng_key),
    .eng_keylen  (eng_keylen),
    .eng_decrypt (eng_decrypt),
    .eng_busy    (eng_busy),
    .eng_result  (eng_result),
    .state_dbg   (state_dbg)
  );

  // Engine stand-in: known vectors map to their results, anything else inverts.
  always_comb begin
    if (!eng_decrypt && eng_keylen == KEY128 && eng_key == K128 && eng_data == P)
      eng_result = C128;
    else if (!eng_decrypt && eng_keylen == KEY192 && eng_key == K192 && eng_data == P)
      eng_result = C192;
    else if (eng_decrypt && eng_keylen == KEY256 && eng_key == K256 && eng_data == C256)
      eng_result = P;
    else
      eng_result = ~eng_data;
  end

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_job(input int r, input logic dec, input logic [1:0] kl,
                         input logic [127:0] d, input logic [255:0] k);
    bus.req_decrypt[r]        = dec;
    bus.req_keylen[r*2 +: 2]  = kl;
    bus.req_data[r*128 +: 128] = d;
    bus.req_key[r*256 +: 256] = k;
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 0;
    while (!bus.resp_valid && cyc < 30) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, k, prev;
    logic [1:0] e;
    reset           = 1'b1;
    bus.req_valid   = '0;
    bus.req_decrypt = '0;
    bus.req_keylen  = '0;
    bus.req_data    = '0;
    bus.req_key     = '0;
    bus.resp_ready  = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_state", state_dbg, ST_IDLE);
    chk("rst_req_ready", bus.req_ready, 2'b00);
    chk("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_resp_id", bus.resp_id, 3'd0);
    chk("rst_resp_data", bus.resp_data, 128'h0);
    chk("rst_resp_err", bus.resp_err, 1'b0);
    chk("rst_eng_busy", eng_busy, 1'b0);
    chk("rst_eng_data", eng_data, 128'h0);
    chk("rst_eng_key", eng_key, 256'h0);

    // Single encrypt-128 job on requester 0; inputs scrambled after accept
    set_job(0, 1'b0, KEY128, P, K128);
    bus.req_valid = 2'b01;
    #1;
    chk("t1_req_ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00;
    set_job(0, 1'b1, KEY256, ~P, K256);
    #1;
    chk("t1_eng_busy", eng_busy, 1'b1);
    chk("t1_eng_data", eng_data, P);
    chk("t1_eng_key", eng_key, K128);
    chk("t1_eng_keylen", eng_keylen, KEY128);
    chk("t1_eng_decrypt", eng_decrypt, 1'b0);
    chk("t1_req_ready_run", bus.req_ready, 2'b00);
    wait_resp(cyc);
    chk("t1_resp_valid", bus.resp_valid, 1'b1);
    chk("t1_latency", cyc, SETTLE);
    chk("t1_resp_id", bus.resp_id, 3'd0);
    chk("t1_resp_data", bus.resp_data, C128);
    chk("t1_resp_err", bus.resp_err, 1'b0);
    chk("t1_eng_busy_resp", eng_busy, 1'b0);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    chk("t1_idle", state_dbg, ST_IDLE);
    chk("t1_resp_valid_low", bus.resp_valid, 1'b0);

    // Reset during RUN discards the job
    set_job(1, 1'b0, KEY128, P, K128);
    bus.req_valid = 2'b10;
    #1;
    chk("t3_req_ready", bus.req_ready, 2'b10);
    tick();
    bus.req_valid = 2'b00;
    chk("t3_run", state_dbg, ST_RUN);
    chk("t3_busy", eng_busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t3_state", state_dbg, ST_IDLE);
    chk("t3_resp_valid", bus.resp_valid, 1'b0);
    chk("t3_eng_busy", eng_busy, 1'b0);
    chk("t3_eng_data", eng_data, 128'h0);
    tick();
    tick();
    chk("t3_no_resp", bus.resp_valid, 1'b0);

    // Two simultaneous jobs: requester 0 first after reset, then requester 1
    set_job(0, 1'b1, KEY256, C256, K256);
    set_job(1, 1'b0, KEY192, P, K192);
    bus.req_valid = 2'b11;
    #1;
    chk("t2_first_grant", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b10;
    wait_resp(cyc);
    chk("t2a_resp_valid", bus.resp_valid, 1'b1);
    chk("t2a_resp_id", bus.resp_id, 3'd0);
    chk("t2a_resp_data", bus.resp_data, P);
    chk("t2a_resp_err", bus.resp_err, 1'b0);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    chk("t2_second_grant", bus.req_ready, 2'b10);
    tick();
    bus.req_valid = 2'b00;
    wait_resp(cyc);
    chk("t2b_resp_valid", bus.resp_valid, 1'b1);
    chk("t2b_resp_id", bus.resp_id, 3'd1);
    chk("t2b_resp_data", bus.resp_data, C192);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;

    // Fairness with both requesters held valid; back-to-back period SETTLE+2
    set_job(0, 1'b0, KEY128, P, K128);
    set_job(1, 1'b0, KEY128, P, K128);
    bus.req_valid  = 2'b11;
    bus.resp_ready = 1'b1;
    #1;
    prev = 0;
    for (int j = 0; j < 6; j++) begin
      k = 0;
      while (bus.req_ready == 2'b00 && k < 10) begin
        tick();
        k++;
      end
      e = (j % 2 == 0) ? 2'b01 : 2'b10;
      chk($sformatf("rr_grant%0d", j), bus.req_ready, e);
      if (j > 0) chk($sformatf("rr_period%0d", j), cyc_cnt - prev, SETTLE + 2);
      prev = cyc_cnt;
      tick();
    end
    bus.req_valid = 2'b00;
    wait_resp(cyc);
    chk("rr_last_id", bus.resp_id, 3'd1);
    tick();
    bus.resp_ready = 1'b0;

    // Illegal key length on requester 1
    set_job(1, 1'b0, KEYBAD, P, K128);
    bus.req_valid = 2'b10;
    #1;
    chk("t4_req_ready", bus.req_ready, 2'b10);
    chk("t4_busy_accept", eng_busy, 1'b0);
    tick();
    bus.req_valid = 2'b00;
    chk("t4_resp_valid", bus.resp_valid, 1'b1);
    chk("t4_resp_err", bus.resp_err, 1'b1);
    chk("t4_resp_data", bus.resp_data, 128'h0);
    chk("t4_resp_id", bus.resp_id, 3'd1);
    chk("t4_eng_busy", eng_busy, 1'b0);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    chk("t4_resp_done", bus.resp_valid, 1'b0);

    // Response backpressure with a pending request from requester 1
    set_job(0, 1'b0, KEY128, P, K128);
    bus.req_valid = 2'b01;
    #1;
    chk("t5_req_ready", bus.req_ready, 2'b01);
    tick();
    set_job(1, 1'b1, KEY256, C256, K256);
    bus.req_valid = 2'b10;
    wait_resp(cyc);
    chk("t5_resp_valid", bus.resp_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t5_hold_valid%0d", i), bus.resp_valid, 1'b1);
      chk($sformatf("t5_hold_data%0d", i), bus.resp_data, C128);
      chk($sformatf("t5_hold_ready%0d", i), bus.req_ready, 2'b00);
      tick();
    end
    bus.resp_ready = 1'b1;
    #1;
    chk("t5_hs_no_accept", bus.req_ready, 2'b00);
    tick();
    bus.resp_ready = 1'b0;
    chk("t5_idle", state_dbg, ST_IDLE);
    chk("t5_next_grant", bus.req_ready, 2'b10);
    tick();
    bus.req_valid = 2'b00;
    chk("t5_next_busy", eng_busy, 1'b1);
    chk("t5_next_dec", eng_decrypt, 1'b1);
    wait_resp(cyc);
    chk("t5_next_id", bus.resp_id, 3'd1);
    chk("t5_next_data", bus.resp_data, P);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_job_scheduler.md
Name: aes_job_scheduler

Overview:
- Round-robin scheduler that shares one AES engine (encrypt and decrypt, 128/192/256-bit keys) between NREQ requesters.
- Each requester submits a job (data, key, key length, direction) over a valid/ready channel.
- The scheduler latches the job, drives the engine for a fixed settle time and captures the result. It returns the result on a single response channel tagged with the requester ID.
- Sits between client blocks (self-test, host interface) and the combinational AES encrypt/decrypt datapaths.

Parameters:
- NREQ, 2, number of requesters (2..8).
- SETTLE_CYCLES, 2, cycles the engine inputs are held stable before the result is sampled (>=1).
- IDW, 3, width of requester ID; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester job valid.
- req_ready  out  NREQ  per-requester accept (one-hot or zero).
- req_decrypt  in  NREQ  1 = decrypt, 0 = encrypt.
- req_keylen  in  2*NREQ  0 = 128-bit, 1 = 192-bit, 2 = 256-bit, 3 = illegal.
- req_data  in  128*NREQ  plaintext/ciphertext block.
- req_key  in  256*NREQ  key, right-aligned (a 128-bit key occupies bits [127:0]).
- eng_data  out  128  engine block input.
- eng_key  out  256  engine key input.
- eng_keylen  out  2  engine key-length select.
- eng_decrypt  out  1  engine direction select.
- eng_busy  out  1  engine inputs valid/held.
- eng_result  in  128  engine output (combinational from eng_*).
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accept.
- resp_id  out  IDW  index of the originating requester.
- resp_data  out  128  result block.
- resp_err  out  1  illegal key length; resp_data = 0.

Behaviour:
- States: IDLE, RUN, RESP.
- Reset values: state IDLE; req_ready 0; eng_busy 0; eng_* registers 0; resp_valid 0; resp_id 0; resp_data 0; resp_err 0; round-robin pointer = NREQ-1, so requester 0 has first priority.
- IDLE:
  - req_ready is combinational and one-hot to the round-robin winner among asserted req_valid. Search starts at pointer+1 and wraps modulo NREQ.
  - On acceptance (cycle T): latch the job, pointer <= winner, resp_id <= winner.
  - Legal keylen: go to RUN with cnt = SETTLE_CYCLES-1.
  - keylen == 3: go to RESP with resp_err=1, resp_data=0; resp_valid rises at T+1. The engine is never driven.
- RUN:
  - eng_busy=1; eng_* are held constant from registers. req_ready is 0 in every state other than IDLE.
  - cnt decrements each cycle.
  - When cnt == 0, capture eng_result into resp_data and go to RESP. The capture happens in cycle T+SETTLE_CYCLES; resp_valid rises at T+SETTLE_CYCLES+1.
- RESP:
  - resp_valid=1; resp_id/resp_data/resp_err are stable until handshake. eng_busy=0.
  - On resp_valid && resp_ready, go to IDLE. No new job is accepted in the handshake cycle.
  - Minimum job period is SETTLE_CYCLES+2 cycles.
- Arbitration fairness: with all requesters continuously valid, grants rotate 0,1,..,NREQ-1,0,...
- Requesters may change inputs after their req_ready cycle; the latched copy is used.
- Requester inputs are ignored outside IDLE.
- Reset mid-operation (RUN or RESP): the job is discarded with no response; all state returns to reset values on the next edge.
- reset has priority over all handshakes in the same cycle.

Decomposition:
- Shared package aes_pkg:
  - keylen encodings KEY128=0, KEY192=1, KEY256=2, KEYBAD=3;
  - key width constants (128/192/256) and Nk/Nr pairs (4/10, 6/12, 8/14);
  - scheduler state enum.
- One sub-module: aes_rr_arbiter. It is combinational: inputs req vector and pointer; outputs one-hot grant, grant index and any_req.
- Engine muxing between the encrypt and decrypt cores lives outside this block.

Test Plan:
- Req0 encrypt, keylen 0, data 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> resp_id 0, resp_data 69c4e0d86a7b0430d8cdb78070b4c55a, resp_err 0, resp_valid at accept+SETTLE_CYCLES+1.
- Req0 and req1 valid together: req0 decrypt 256-bit (8ea2b7ca516745bfeafc49904b496089, key 000102..1f), req1 encrypt 192-bit (key 000102..17) -> req0 granted first returning 00112233445566778899aabbccddeeff, then req1 returning dda97ca4864cdfe06eaf70a0ec0d7191.
- Both requesters held valid for 6 jobs -> grant order 0,1,0,1,0,1; no requester granted twice consecutively.
- Req1 with keylen 3 -> resp_err 1, resp_data 0, resp_valid one cycle after accept, eng_busy never asserted.
- resp_ready held low 10 cycles in RESP -> resp_* stable, req_ready stays 0 despite pending req_valid; job accepted the cycle after the handshake.
- reset asserted during RUN -> next cycle resp_valid 0, eng_busy 0, state IDLE; the next job goes to requester 0 first.
